// File: rtl/psum_requant_packer.sv
// psum_requant_packer
// Converts signed partial sums back to int8 activations: round half toward
// +inf, arithmetic right shift, optional ReLU, saturate to int8. Four results
// are packed per output word, lane 0 first. A single global advance signal
// moves the whole two-stage pipe, so downstream backpressure freezes
// everything, including a partially filled word.

module psum_requant_packer #(
  parameter int LANES  = 4,
  parameter int PSUM_W = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           cfg_shift,
  input  logic                 cfg_relu,
  input  logic                 psum_valid,
  output logic                 psum_ready,
  input  logic [PSUM_W-1:0]    psum_data,
  input  logic                 psum_last,
  output logic                 ofmap_valid,
  input  logic                 ofmap_ready,
  output logic [8*LANES-1:0]   ofmap_data,
  output logic [LANES-1:0]     ofmap_keep,
  output logic                 ofmap_last
);

  // One guard bit above the psum keeps the rounding add from overflowing.
  localparam int XW = PSUM_W + 1;
  localparam int CW = $clog2(LANES);

  localparam logic [4:0]           SHIFT_MAX = 5'(PSUM_W - 1);
  localparam logic [CW-1:0]        CNT_LAST  = CW'(LANES - 1);
  localparam logic signed [XW-1:0] SAT_HI    = XW'(127);
  localparam logic signed [XW-1:0] SAT_LO    = XW'(-128);

  // ReLU (optional) followed by clamping to the int8 range.
  function automatic logic [7:0] relu_sat(input logic signed [XW-1:0] r,
                                          input logic relu);
    logic [7:0] b;
    if (relu && (r[XW-1] == 1'b1)) begin
      b = 8'h00;
    end else if (r > SAT_HI) begin
      b = 8'h7F;
    end else if (r < SAT_LO) begin
      b = 8'h80;
    end else begin
      b = r[7:0];
    end
    return b;
  endfunction

  // Registers
  logic                   ready_en_q, ready_en_d;
  logic                   s1_valid_q, s1_valid_d;
  logic signed [XW-1:0]   s1_r_q, s1_r_d;
  logic                   s1_last_q, s1_last_d;
  logic                   s1_relu_q, s1_relu_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [LANES-1:0][7:0]  lane_q, lane_d;
  logic [LANES-1:0]       keep_q, keep_d;
  logic                   ofmap_valid_q, ofmap_valid_d;
  logic [8*LANES-1:0]     ofmap_data_q, ofmap_data_d;
  logic [LANES-1:0]       ofmap_keep_q, ofmap_keep_d;
  logic                   ofmap_last_q, ofmap_last_d;

  // Combinational helpers
  logic                   adv_s;
  logic                   accept_s;
  logic [4:0]             shift_s;
  logic signed [XW-1:0]   rnd_s;
  logic signed [XW-1:0]   x_s;
  logic signed [XW-1:0]   r_s;
  logic [7:0]             byte_s;
  logic [LANES-1:0][7:0]  lane_fill_s;
  logic [LANES-1:0]       keep_fill_s;

  // Global advance and input handshake; ready stays low until the first edge after reset.
  always_comb begin
    adv_s      = (!ofmap_valid_q) | ofmap_ready;
    psum_ready = ready_en_q & adv_s;
    accept_s   = psum_valid & psum_ready;
  end

  // Stage 1: round, then arithmetic shift using the beat's own config.
  always_comb begin
    shift_s = (cfg_shift > SHIFT_MAX) ? SHIFT_MAX : cfg_shift;
    if (shift_s == 5'd0) begin
      rnd_s = '0;
    end else begin
      rnd_s = XW'(1) << (shift_s - 5'd1);
    end
    x_s = $signed({psum_data[PSUM_W-1], psum_data}) + rnd_s;
    r_s = x_s >>> shift_s;

    ready_en_d = 1'b1;
    s1_valid_d = s1_valid_q;
    s1_r_d     = s1_r_q;
    s1_last_d  = s1_last_q;
    s1_relu_d  = s1_relu_q;
    if (adv_s) begin
      s1_valid_d = accept_s;
      if (accept_s) begin
        s1_r_d    = r_s;
        s1_last_d = psum_last;
        s1_relu_d = cfg_relu;
      end else begin
        s1_r_d    = s1_r_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage 2: drop the clamped byte into the next lane and emit a word when full or on last.
  always_comb begin
    byte_s      = relu_sat(s1_r_q, s1_relu_q);
    lane_fill_s = lane_q;
    lane_fill_s[cnt_q] = byte_s;
    keep_fill_s = keep_q | (LANES'(1) << cnt_q);

    cnt_d         = cnt_q;
    lane_d        = lane_q;
    keep_d        = keep_q;
    ofmap_valid_d = ofmap_valid_q;
    ofmap_data_d  = ofmap_data_q;
    ofmap_keep_d  = ofmap_keep_q;
    ofmap_last_d  = ofmap_last_q;
    if (adv_s) begin
      // Any held word retires here; it is replaced only if a new one completes.
      ofmap_valid_d = 1'b0;
      if (s1_valid_q) begin
        if ((cnt_q == CNT_LAST) || s1_last_q) begin
          ofmap_valid_d = 1'b1;
          ofmap_data_d  = lane_fill_s;
          ofmap_keep_d  = keep_fill_s;
          ofmap_last_d  = s1_last_q;
          lane_d        = '0;
          keep_d        = '0;
          cnt_d         = '0;
        end else begin
          lane_d = lane_fill_s;
          keep_d = keep_fill_s;
          cnt_d  = cnt_q + CW'(1);
        end
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      ofmap_valid_d = ofmap_valid_q;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q    <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_r_q        <= '0;
      s1_last_q     <= 1'b0;
      s1_relu_q     <= 1'b0;
      cnt_q         <= '0;
      lane_q        <= '0;
      keep_q        <= '0;
      ofmap_valid_q <= 1'b0;
      ofmap_data_q  <= '0;
      ofmap_keep_q  <= '0;
      ofmap_last_q  <= 1'b0;
    end else begin
      ready_en_q    <= ready_en_d;
      s1_valid_q    <= s1_valid_d;
      s1_r_q        <= s1_r_d;
      s1_last_q     <= s1_last_d;
      s1_relu_q     <= s1_relu_d;
      cnt_q         <= cnt_d;
      lane_q        <= lane_d;
      keep_q        <= keep_d;
      ofmap_valid_q <= ofmap_valid_d;
      ofmap_data_q  <= ofmap_data_d;
      ofmap_keep_q  <= ofmap_keep_d;
      ofmap_last_q  <= ofmap_last_d;
    end
  end

  // Output ports are driven straight from flops.
  always_comb begin
    ofmap_valid = ofmap_valid_q;
    ofmap_data  = ofmap_data_q;
    ofmap_keep  = ofmap_keep_q;
    ofmap_last  = ofmap_last_q;
  end

endmodule

// File: tb/tb_psum_requant_packer.sv
// Testbench for psum_requant_packer: directed words from the reference
// vectors plus a reference model feeding a scoreboard for streamed traffic.

module tb_psum_requant_packer;

  logic        clk;
  logic        rst_n;
  logic [4:0]  cfg_shift;
  logic        cfg_relu;
  logic        psum_valid;
  logic        psum_ready;
  logic [23:0] psum_data;
  logic        psum_last;
  logic        ofmap_valid;
  logic        ofmap_ready;
  logic [31:0] ofmap_data;
  logic [3:0]  ofmap_keep;
  logic        ofmap_last;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } word_t;

  word_t exp_q[$];
  word_t mon_w;
  int    checks = 0;
  int    errors = 0;
  bit    use_model = 1'b0;

  logic [3:0][7:0] m_lanes;
  logic [3:0]      m_keep;
  int              m_cnt;

  psum_requant_packer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_shift  (cfg_shift),
    .cfg_relu   (cfg_relu),
    .psum_valid (psum_valid),
    .psum_ready (psum_ready),
    .psum_data  (psum_data),
    .psum_last  (psum_last),
    .ofmap_valid(ofmap_valid),
    .ofmap_ready(ofmap_ready),
    .ofmap_data (ofmap_data),
    .ofmap_keep (ofmap_keep),
    .ofmap_last (ofmap_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: floor((p + half) / 2^s), then ReLU and int8 clamp.
  function automatic logic [7:0] ref_byte(input logic [23:0] p, input logic [4:0] sh,
                                          input logic relu);
    longint v, d, q;
    int s;
    s = (sh > 5'd23) ? 23 : int'(sh);
    v = longint'($signed(p));
    d = longint'(1) << s;
    v = v + (d / 2);
    if (v >= 0) q = v / d;
    else        q = -((-v + d - 1) / d);
    if (relu && q < 0) q = 0;
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
    return q[7:0];
  endfunction

  task automatic model_clear();
    m_lanes = '0;
    m_keep  = '0;
    m_cnt   = 0;
  endtask

  task automatic model_accept(input logic [23:0] p, input logic last, input logic [4:0] sh,
                              input logic relu);
    word_t w;
    m_lanes[m_cnt] = ref_byte(p, sh, relu);
    m_keep[m_cnt]  = 1'b1;
    if (m_cnt == 3 || last) begin
      w.d = m_lanes;
      w.k = m_keep;
      w.l = last;
      exp_q.push_back(w);
      model_clear();
    end else begin
      m_cnt = m_cnt + 1;
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
    word_t w;
    w.d = d;
    w.k = k;
    w.l = l;
    exp_q.push_back(w);
  endtask

  // Present one beat and hold it until the handshake completes.
  task automatic send_beat(input logic [23:0] p, input logic last, input logic [4:0] sh,
                           input logic relu);
    bit ok;
    ok = 1'b0;
    psum_valid = 1'b1;
    psum_data  = p;
    psum_last  = last;
    cfg_shift  = sh;
    cfg_relu   = relu;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (psum_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout psum=%h never accepted", p);
    end else if (use_model) begin
      model_accept(p, last, sh, relu);
    end
    @(posedge clk);
    #1;
    psum_valid = 1'b0;
    psum_last  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) break;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d words outstanding, expected 0", name, exp_q.size());
    end
  endtask

  // Scoreboard: compare every retiring word with the oldest expected word.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ofmap_valid === 1'b1 && ofmap_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word got data=%h keep=%h last=%b, expected none",
                 ofmap_data, ofmap_keep, ofmap_last);
      end else begin
        mon_w = exp_q.pop_front();
        if ({ofmap_data, ofmap_keep, ofmap_last} !== mon_w) begin
          errors++;
          $display("FAIL word got data=%h keep=%h last=%b, expected data=%h keep=%h last=%b",
                   ofmap_data, ofmap_keep, ofmap_last, mon_w.d, mon_w.k, mon_w.l);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    psum_valid = 1'b0;
    psum_data = '0;
    psum_last = 1'b0;
    cfg_shift = '0;
    cfg_relu = 1'b0;
    ofmap_ready = 1'b1;
    model_clear();
    #3;
    checks++;
    if ({psum_ready, ofmap_valid, ofmap_data, ofmap_keep, ofmap_last} !== 39'd0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b v=%b d=%h k=%h l=%b, expected all 0",
               psum_ready, ofmap_valid, ofmap_data, ofmap_keep, ofmap_last);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (psum_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_held got %b, expected 0", psum_ready);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (psum_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_release got %b, expected 1", psum_ready);
    end
  endtask

  task automatic test_rounding();
    use_model = 1'b0;
    push_exp(32'h0101FF02, 4'hF, 1'b0);
    send_beat(24'h000018, 1'b0, 5'd4, 1'b0);
    send_beat(24'hFFFFE8, 1'b0, 5'd4, 1'b0);
    send_beat(24'h000017, 1'b0, 5'd4, 1'b0);
    send_beat(24'h000008, 1'b0, 5'd4, 1'b0);
    wait_drain("rounding");
  endtask

  task automatic test_saturate();
    use_model = 1'b0;
    push_exp(32'h0005807F, 4'h7, 1'b1);
    send_beat(24'h7FFFFF, 1'b0, 5'd0, 1'b0);
    send_beat(24'h800000, 1'b0, 5'd0, 1'b0);
    send_beat(24'h000005, 1'b1, 5'd0, 1'b0);
    wait_drain("saturate");
  endtask

  task automatic test_relu();
    use_model = 1'b0;
    push_exp(32'h00030001, 4'hF, 1'b0);
    send_beat(24'h000001, 1'b0, 5'd0, 1'b1);
    send_beat(24'hFFFFFB, 1'b0, 5'd0, 1'b1);
    send_beat(24'h000003, 1'b0, 5'd0, 1'b1);
    send_beat(24'h800000, 1'b0, 5'd0, 1'b1);
    wait_drain("relu");
  endtask

  task automatic test_last_flush();
    use_model = 1'b0;
    push_exp(32'h00000201, 4'h3, 1'b1);
    push_exp(32'h00000009, 4'h1, 1'b1);
    push_exp(32'h0001FF01, 4'hF, 1'b1);
    send_beat(24'h000001, 1'b0, 5'd0, 1'b0);
    send_beat(24'h000002, 1'b1, 5'd0, 1'b0);
    send_beat(24'h000009, 1'b1, 5'd0, 1'b0);
    // shift above 23 behaves as 23; last on the fourth lane
    send_beat(24'h7FFFFF, 1'b0, 5'd31, 1'b0);
    send_beat(24'h800000, 1'b0, 5'd24, 1'b0);
    send_beat(24'h400000, 1'b0, 5'd23, 1'b0);
    send_beat(24'h000000, 1'b1, 5'd23, 1'b0);
    wait_drain("last_flush");
  endtask

  task automatic test_mixed_cfg();
    use_model = 1'b0;
    push_exp(32'h01F00002, 4'hF, 1'b1);
    send_beat(24'h000018, 1'b0, 5'd4, 1'b0);
    send_beat(24'hFFFFF0, 1'b0, 5'd0, 1'b1);
    send_beat(24'hFFFFF0, 1'b0, 5'd0, 1'b0);
    send_beat(24'h000100, 1'b1, 5'd8, 1'b0);
    wait_drain("mixed_cfg");
  endtask

  task automatic test_latency();
    use_model = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(24'(i * 40), 1'b0, 5'd3, 1'b0);
    @(negedge clk);
    checks++;
    if (ofmap_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early got valid=%b, expected 0", ofmap_valid);
    end
    @(negedge clk);
    checks++;
    if (ofmap_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency_two got valid=%b, expected 1", ofmap_valid);
    end
    wait_drain("latency");
  endtask

  task automatic test_backpressure();
    bit seen;
    logic [36:0] snap;
    use_model = 1'b1;
    seen = 1'b0;
    snap = '0;
    ofmap_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++)
          send_beat(24'($urandom), 1'b0, 5'($urandom_range(0, 10)), 1'($urandom_range(0, 1)));
      end
      begin
        for (int i = 0; i < 300; i++) begin
          @(negedge clk);
          if (ofmap_valid === 1'b1) begin
            seen = 1'b1;
            break;
          end
        end
        checks++;
        if (!seen) begin
          errors++;
          $display("FAIL stall_first_word got no word, expected one");
        end
        snap = {ofmap_data, ofmap_keep, ofmap_last};
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          checks++;
          if ({ofmap_valid, ofmap_data, ofmap_keep, ofmap_last, psum_ready} !== {1'b1, snap, 1'b0}) begin
            errors++;
            $display("FAIL stall_stable cycle %0d got v=%b d=%h k=%h l=%b rdy=%b, expected v=1 %h rdy=0",
                     c, ofmap_valid, ofmap_data, ofmap_keep, ofmap_last, psum_ready, snap);
          end
        end
        @(posedge clk);
        #1;
        ofmap_ready = 1'b1;
      end
    join
    wait_drain("backpressure");
  endtask

  task automatic test_reset_midword();
    use_model = 1'b1;
    send_beat(24'h000050, 1'b0, 5'd2, 1'b0);
    send_beat(24'h000060, 1'b0, 5'd2, 1'b0);
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if ({psum_ready, ofmap_valid, ofmap_data, ofmap_keep, ofmap_last} !== 39'd0) begin
      errors++;
      $display("FAIL midword_reset got rdy=%b v=%b d=%h k=%h l=%b, expected all 0",
               psum_ready, ofmap_valid, ofmap_data, ofmap_keep, ofmap_last);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({psum_ready, ofmap_valid} !== 2'b10) begin
      errors++;
      $display("FAIL midword_release got rdy=%b v=%b, expected rdy=1 v=0", psum_ready, ofmap_valid);
    end
    send_beat(24'h000011, 1'b0, 5'd0, 1'b0);
    send_beat(24'h000022, 1'b0, 5'd0, 1'b0);
    send_beat(24'h000033, 1'b0, 5'd0, 1'b0);
    send_beat(24'h000044, 1'b0, 5'd0, 1'b0);
    wait_drain("midword");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rounding();
    test_saturate();
    test_relu();
    test_last_flush();
    test_mixed_cfg();
    test_latency();
    test_backpressure();
    test_reset_midword();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
